// File: rtl/lcd_cmd_seq_pkg.sv
// Shared command codes, state encoding and frame geometry for the LCD command sequencer.
package lcd_pkg;

  typedef logic [2:0] cmd_t;

  localparam cmd_t CMD_REFLASH  = 3'd0;
  localparam cmd_t CMD_LOAD     = 3'd1;
  localparam cmd_t CMD_ZOOM_IN  = 3'd2;
  localparam cmd_t CMD_ZOOM_OUT = 3'd3;
  localparam cmd_t CMD_RIGHT    = 3'd4;
  localparam cmd_t CMD_LEFT     = 3'd5;
  localparam cmd_t CMD_UP       = 3'd6;
  localparam cmd_t CMD_DOWN     = 3'd7;

  localparam int IMG_BYTES = 64;
  localparam int FRAME_PIX = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_LOAD,
    ST_WAIT,
    ST_FRAME
  } state_t;

endpackage

// File: rtl/lcd_cmd_seq_if.sv
// Command/pixel handshake between the sequencer (master) and the LCD image controller (slave).
interface lcd_cmd_seq_if;

  lcd_pkg::cmd_t lcd_cmd;
  logic          lcd_cmd_valid;
  logic [7:0]    lcd_datain;
  logic          lcd_busy;
  logic [7:0]    lcd_dataout;
  logic          lcd_output_valid;

  modport master (
    output lcd_cmd, lcd_cmd_valid, lcd_datain,
    input  lcd_busy, lcd_dataout, lcd_output_valid
  );

  modport slave (
    input  lcd_cmd, lcd_cmd_valid, lcd_datain,
    output lcd_busy, lcd_dataout, lcd_output_valid
  );

endinterface

// File: rtl/lcd_cmd_seq_fifo.sv
// Synchronous DEPTH x 3 command FIFO; head is visible combinationally, no write-through bypass.
module lcd_cmd_fifo
  import lcd_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  cmd_t push_data,
  input  logic pop,
  output cmd_t head,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  cmd_t        mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        push_ok;
  logic        pop_ok;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  // Extra pointer bit separates full from empty when the indices coincide.
  assign head  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/lcd_cmd_seq.sv
// Host-to-LCD command sequencer: queues commands, streams the image on LOAD, forwards each 16-pixel frame.
module lcd_cmd_seq
  import lcd_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  cmd_t          host_cmd,
  input  logic          host_valid,
  output logic          host_ready,
  output logic [5:0]    img_addr,
  input  logic [7:0]    img_rdata,
  lcd_cmd_seq_if.master lcd,
  output logic [7:0]    pix_out,
  output logic          pix_valid,
  output logic [3:0]    pix_idx,
  output logic          frame_done,
  output logic          err
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  state_t          state;
  state_t          state_next;
  cmd_t            cmd_q;
  logic [5:0]      byte_cnt;
  logic [WD_W-1:0] wd_cnt;
  logic [3:0]      beat_cnt;
  logic            loaded;

  logic            fifo_pop;
  logic            fifo_full;
  logic            fifo_empty;
  cmd_t            fifo_head;

  logic            gate_drop;
  logic            wd_hit;
  logic            wd_fire;
  logic            beat_take;
  logic            last_beat;

  assign host_ready = !fifo_full;

  lcd_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (host_valid && host_ready),
    .push_data (host_cmd),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  assign wd_hit = (wd_cnt == WD_W'(TIMEOUT - 1));

  always_comb begin
    state_next        = state;
    fifo_pop          = 1'b0;
    gate_drop         = 1'b0;
    wd_fire           = 1'b0;
    beat_take         = 1'b0;
    last_beat         = 1'b0;
    lcd.lcd_cmd       = '0;
    lcd.lcd_cmd_valid = 1'b0;
    lcd.lcd_datain    = '0;
    img_addr          = '0;
    case (state)
      ST_IDLE: begin
        // Nothing but LOAD may reach the controller until an image has been loaded.
        if (!fifo_empty && !lcd.lcd_busy) begin
          fifo_pop = 1'b1;
          if (loaded || fifo_head == CMD_LOAD) state_next = ST_ISSUE;
          else                                 gate_drop  = 1'b1;
        end
      end
      ST_ISSUE: begin
        lcd.lcd_cmd       = cmd_q;
        lcd.lcd_cmd_valid = 1'b1;
        state_next        = (cmd_q == CMD_LOAD) ? ST_LOAD : ST_WAIT;
      end
      ST_LOAD: begin
        lcd.lcd_datain = img_rdata;
        img_addr       = (byte_cnt == 6'(IMG_BYTES - 1)) ? byte_cnt : byte_cnt + 6'd1;
        if (byte_cnt == 6'(IMG_BYTES - 1)) state_next = ST_WAIT;
        if (wd_hit) begin
          wd_fire    = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (lcd.lcd_output_valid) begin
          beat_take  = 1'b1;
          state_next = ST_FRAME;
        end
        if (wd_hit) begin
          wd_fire    = 1'b1;
          beat_take  = 1'b0;
          state_next = ST_IDLE;
        end
      end
      ST_FRAME: begin
        if (lcd.lcd_output_valid) begin
          beat_take = 1'b1;
          if (beat_cnt == 4'(FRAME_PIX - 1)) begin
            last_beat  = 1'b1;
            state_next = ST_IDLE;
          end
        end
        // A final beat landing on the timeout still completes the frame.
        if (wd_hit && !last_beat) begin
          wd_fire    = 1'b1;
          beat_take  = 1'b0;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Stage p1: counters, sticky flags and the registered pixel forward.
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_q      <= '0;
      byte_cnt   <= '0;
      wd_cnt     <= '0;
      beat_cnt   <= '0;
      loaded     <= 1'b0;
      err        <= 1'b0;
      pix_out    <= '0;
      pix_valid  <= 1'b0;
      pix_idx    <= '0;
      frame_done <= 1'b0;
    end else begin
      pix_valid  <= beat_take;
      frame_done <= last_beat;
      if (beat_take) begin
        pix_out  <= lcd.lcd_dataout;
        pix_idx  <= beat_cnt;
        beat_cnt <= beat_cnt + 4'd1;
      end
      if (fifo_pop) cmd_q <= fifo_head;
      if (gate_drop || wd_fire) err <= 1'b1;
      case (state)
        ST_ISSUE: begin
          byte_cnt <= '0;
          beat_cnt <= '0;
          wd_cnt   <= WD_W'(1);
          if (cmd_q == CMD_LOAD) loaded <= 1'b1;
        end
        ST_LOAD: begin
          byte_cnt <= byte_cnt + 6'd1;
          wd_cnt   <= wd_cnt + WD_W'(1);
        end
        ST_WAIT, ST_FRAME: wd_cnt <= wd_cnt + WD_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_cmd_seq.sv
// Scoreboard bench for lcd_cmd_seq with a behavioural LCD controller and image memory.
module tb_lcd_cmd_seq;
  import lcd_pkg::*;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 255;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  cmd_t       host_cmd = '0;
  logic       host_valid = 1'b0;
  logic       host_ready;
  logic [5:0] img_addr;
  logic [7:0] img_rdata = '0;
  logic [7:0] pix_out;
  logic       pix_valid;
  logic [3:0] pix_idx;
  logic       frame_done;
  logic       err;

  lcd_cmd_seq_if lcd_bus ();

  lcd_cmd_seq #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .host_cmd   (host_cmd),
    .host_valid (host_valid),
    .host_ready (host_ready),
    .img_addr   (img_addr),
    .img_rdata  (img_rdata),
    .lcd        (lcd_bus),
    .pix_out    (pix_out),
    .pix_valid  (pix_valid),
    .pix_idx    (pix_idx),
    .frame_done (frame_done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] img_mem [64];
  always @(posedge clk) img_rdata <= img_mem[img_addr];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  cmd_t        exp_cmd_q [$];
  logic [11:0] exp_pix_q [$];

  int   n_issued = 0, n_accepted = 0, n_frames = 0, n_pix = 0;
  int   issue_cyc = 0, push_cyc = 0;
  logic hang = 1'b0, hold_busy = 1'b0;

  // LCD controller model: phase 0 idle, 1 loading, 2 pre-frame delay, 3 beats, 4 tail, 5 hung.
  int   phase = 0, k = 0, dly = 0, beat = 0;
  logic drv_busy = 1'b0, hang_job = 1'b0, gapped = 1'b0;
  cmd_t cur_cmd = '0;

  initial begin
    lcd_bus.lcd_busy         = 1'b0;
    lcd_bus.lcd_dataout      = '0;
    lcd_bus.lcd_output_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        phase = 0;
        drv_busy = 1'b0;
        lcd_bus.lcd_busy = 1'b0;
        lcd_bus.lcd_output_valid = 1'b0;
        lcd_bus.lcd_dataout = '0;
      end else begin
        lcd_bus.lcd_output_valid = 1'b0;
        if (lcd_bus.lcd_cmd_valid) begin
          chk("issue_busy_low", 32'(lcd_bus.lcd_busy), 32'd0);
          chk("issue_model_idle", 32'(phase), 32'd0);
          chk("issue_cmd", 32'(lcd_bus.lcd_cmd),
              (exp_cmd_q.size() > 0) ? 32'(exp_cmd_q.pop_front()) : 32'hDEAD);
          n_issued++;
          issue_cyc = cyc;
          cur_cmd   = lcd_bus.lcd_cmd;
          hang_job  = hang;
          gapped    = 1'b0;
          drv_busy  = 1'b1;
          k = 0;
          dly = 3;
          phase = (lcd_bus.lcd_cmd == CMD_LOAD) ? 1 : 2;
        end else begin
          case (phase)
            1: begin
              chk("load_datain", 32'(lcd_bus.lcd_datain), 32'(img_mem[k]));
              k++;
              if (k == 64) begin
                phase = 2;
                dly = 3;
              end
            end
            2: begin
              if (hang_job)      phase = 5;
              else if (dly == 0) begin
                phase = 3;
                beat = 0;
              end else dly--;
            end
            3: begin
              if (beat == 6 && !gapped) gapped = 1'b1;
              else begin
                lcd_bus.lcd_output_valid = 1'b1;
                lcd_bus.lcd_dataout = 8'(32'(cur_cmd) * 37 + beat * 5 + n_issued);
                exp_pix_q.push_back({4'(beat), lcd_bus.lcd_dataout});
                beat++;
                if (beat == 16) begin
                  phase = 4;
                  dly = 2;
                end
              end
            end
            4: begin
              if (dly == 0) begin
                drv_busy = 1'b0;
                phase = 0;
              end else dly--;
            end
            5: begin
              if (!hang) begin
                drv_busy = 1'b0;
                phase = 0;
              end
            end
            default: ;
          endcase
        end
        lcd_bus.lcd_busy = drv_busy | hold_busy;
      end
    end
  end

  // Forwarded-pixel monitor against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (pix_valid) begin
          chk("pix_idx_data", 32'({pix_idx, pix_out}),
              (exp_pix_q.size() > 0) ? 32'(exp_pix_q.pop_front()) : 32'hDEAD);
          n_pix++;
        end
        if (frame_done) begin
          chk("frame_done_on_pix15", 32'({pix_valid, pix_idx}), 32'h1F);
          n_frames++;
        end
      end
    end
  end

  task automatic push(input cmd_t c, input bit expect_issue);
    int w = 0;
    while (!host_ready && w < 2000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 2000) chk("push_ready_wait", 32'(host_ready), 32'd1);
    host_cmd   = c;
    host_valid = 1'b1;
    push_cyc   = cyc;
    n_accepted++;
    if (expect_issue) exp_cmd_q.push_back(c);
    @(negedge clk);
    host_valid = 1'b0;
  endtask

  task automatic wait_frames(input int target, input int budget, input string tag);
    int n = 0;
    while (n_frames < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(n_frames), 32'(target));
  endtask

  task automatic check_rst_vals(input string tag);
    chk({tag, "_host_ready"}, 32'(host_ready), 32'd1);
    chk({tag, "_cmd_valid"},  32'(lcd_bus.lcd_cmd_valid), 32'd0);
    chk({tag, "_cmd"},        32'(lcd_bus.lcd_cmd), 32'd0);
    chk({tag, "_datain"},     32'(lcd_bus.lcd_datain), 32'd0);
    chk({tag, "_img_addr"},   32'(img_addr), 32'd0);
    chk({tag, "_pix"},        32'({pix_valid, pix_idx, pix_out}), 32'd0);
    chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    chk({tag, "_err"},        32'(err), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset      = 1'b1;
    host_valid = 1'b0;
    hold_busy  = 1'b0;
    hang       = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_cmd_q.delete();
    exp_pix_q.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int base_f, base_p, base_i, base_a, n, err_cyc;
    for (int i = 0; i < 64; i++) img_mem[i] = 8'(i);

    repeat (3) @(negedge clk);
    check_rst_vals("reset");
    reset = 1'b0;

    // Reset then LOAD: ramp image, one frame.
    base_f = n_frames;
    base_p = n_pix;
    push(CMD_LOAD, 1'b1);
    wait_frames(base_f + 1, 400, "t1_frame");
    chk("t1_issue_latency", 32'(issue_cyc - push_cyc), 32'd2);
    chk("t1_pix_count", 32'(n_pix - base_p), 32'd16);
    chk("t1_err", 32'(err), 32'd0);

    // Non-LOAD command before any LOAD is dropped and flagged.
    do_reset();
    base_i = n_issued;
    base_f = n_frames;
    push(CMD_ZOOM_IN, 1'b0);
    repeat (6) @(negedge clk);
    chk("t2_err_set", 32'(err), 32'd1);
    chk("t2_not_issued", 32'(n_issued - base_i), 32'd0);
    push(CMD_LOAD, 1'b1);
    wait_frames(base_f + 1, 400, "t2_load_frame");
    chk("t2_err_sticky", 32'(err), 32'd1);

    // Queued commands back-to-back with a different image.
    do_reset();
    for (int i = 0; i < 64; i++) img_mem[i] = 8'(i * 7 + 3);
    base_i = n_issued;
    base_f = n_frames;
    push(CMD_LOAD, 1'b1);
    push(CMD_ZOOM_IN, 1'b1);
    push(CMD_RIGHT, 1'b1);
    push(CMD_RIGHT, 1'b1);
    wait_frames(base_f + 4, 800, "t3_frames");
    chk("t3_issued", 32'(n_issued - base_i), 32'd4);
    chk("t3_err", 32'(err), 32'd0);

    // FIFO full while the controller is held busy.
    do_reset();
    hold_busy = 1'b1;
    @(negedge clk);
    base_i = n_issued;
    base_a = n_accepted;
    base_f = n_frames;
    fork
      begin
        push(CMD_LOAD, 1'b1);
        push(CMD_ZOOM_IN, 1'b1);
        push(CMD_RIGHT, 1'b1);
        push(CMD_LEFT, 1'b1);
        push(CMD_UP, 1'b1);
        push(CMD_DOWN, 1'b1);
      end
      begin
        repeat (12) @(negedge clk);
        chk("t4_ready_low_full", 32'(host_ready), 32'd0);
        chk("t4_accepted_depth", 32'(n_accepted - base_a), 32'(DEPTH));
        chk("t4_no_issue_busy", 32'(n_issued - base_i), 32'd0);
        hold_busy = 1'b0;
      end
    join
    wait_frames(base_f + 6, 1500, "t4_frames");
    chk("t4_issued", 32'(n_issued - base_i), 32'd6);

    // Watchdog: controller never produces a frame.
    do_reset();
    hang = 1'b1;
    base_f = n_frames;
    base_p = n_pix;
    push(CMD_LOAD, 1'b1);
    n = 0;
    while (!err && n < 600) begin
      @(negedge clk);
      n++;
    end
    err_cyc = cyc;
    chk("t5_err_set", 32'(err), 32'd1);
    chk("t5_wd_latency", 32'(err_cyc - issue_cyc), 32'(TIMEOUT));
    chk("t5_idle_outputs", 32'({lcd_bus.lcd_cmd_valid, lcd_bus.lcd_cmd, lcd_bus.lcd_datain, img_addr}), 32'd0);
    repeat (5) @(negedge clk);
    chk("t5_no_frame", 32'(n_frames - base_f), 32'd0);
    chk("t5_no_pix", 32'(n_pix - base_p), 32'd0);
    hang = 1'b0;
    push(CMD_REFLASH, 1'b1);
    wait_frames(base_f + 1, 300, "t5_recover_frame");
    chk("t5_err_sticky", 32'(err), 32'd1);

    // Reset in the middle of LOAD, then a clean LOAD from byte 0.
    do_reset();
    base_f = n_frames;
    push(CMD_LOAD, 1'b1);
    n = 0;
    while (!(phase == 1 && k >= 30) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("t6_in_load", 32'(phase), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check_rst_vals("t6_mid_load");
    @(negedge clk);
    reset = 1'b0;
    exp_cmd_q.delete();
    exp_pix_q.delete();
    push(CMD_LOAD, 1'b1);
    wait_frames(base_f + 1, 400, "t6_reload_frame");
    chk("t6_err", 32'(err), 32'd0);

    repeat (5) @(negedge clk);
    chk("cmd_q_drained", 32'(exp_cmd_q.size()), 32'd0);
    chk("pix_q_drained", 32'(exp_pix_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
